// File: rtl/example_or_sched.sv
// example_or_sched: round-robin scheduler sharing one OR unit among NREQ requesters
module example_or_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      op_a,
  output logic [W-1:0]      op_b,
  input  logic [W-1:0]      op_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_z,
  output logic [CNTW-1:0]   done_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state, nxt;
  logic [IDW-1:0] ptr, g;
  logic any, accept;
  always_comb begin
    g = '0;
    any = 1'b0;
    for (int k = NREQ; k >= 1; k--)
      if (req_valid[IDW'((int'(ptr) + k) % NREQ)]) begin
        g = IDW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
  end
  assign accept = state == IDLE && any;
  assign req_ready = (!reset && accept) ? NREQ'(1) << g : '0;
  always_comb nxt = state == IDLE ? (any ? ISSUE : IDLE) : state == ISSUE ? HOLD : rsp_ready ? IDLE : HOLD;
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= IDW'(NREQ - 1);
      op_a <= '0;
      op_b <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_z <= '0;
      done_cnt <= '0;
    end else begin
      if (accept) begin
        op_a <= req_a[int'(g)*W +: W];
        op_b <= req_b[int'(g)*W +: W];
        rsp_id <= g;
        ptr <= g;
      end
      if (state == ISSUE) begin
        rsp_z <= op_z;
        rsp_valid <= 1'b1;
      end
      if (state == HOLD && rsp_ready) begin
        rsp_valid <= 1'b0;
        done_cnt <= done_cnt + CNTW'(1);
      end
    end
  end
endmodule

// File: tb/tb_example_or_sched.sv
// tb_example_or_sched: directed self-checking bench for example_or_sched
module tb_example_or_sched;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req_valid;
  logic [31:0] req_a, req_b;
  logic rsp_ready;
  logic [3:0] req_ready, req_ready2;
  logic [7:0] op_a, op_b, op_z, rsp_z, op_a2, op_b2, op_z2, rsp_z2;
  logic rsp_valid, rsp_valid2;
  logic [1:0] rsp_id, rsp_id2;
  logic [15:0] done_cnt;
  logic [1:0] done_cnt2;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign op_z = op_a | op_b;
  assign op_z2 = op_a2 | op_b2;
  example_or_sched u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b), .op_z(op_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .done_cnt(done_cnt)
  );
  example_or_sched #(.CNTW(2)) u_wrap (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .op_a(op_a2), .op_b(op_b2), .op_z(op_z2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2),
    .rsp_z(rsp_z2), .done_cnt(done_cnt2)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    req_a = 32'h44332211;
    req_b = 32'h0;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    total++; if (rsp_z !== 8'h00) begin bad++; $display("FAIL reset_rsp_z got=%h exp=00", rsp_z); end
    total++; if (done_cnt !== 16'd0) begin bad++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
    total++; if ({op_a, op_b} !== 16'h0) begin bad++; $display("FAIL reset_ops got=%h exp=0000", {op_a, op_b}); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    tick();
    total++; if (op_a !== 8'h11 || rsp_id !== 2'd0) begin bad++; $display("FAIL reset_first_accept got op_a=%h id=%0d exp op_a=11 id=0", op_a, rsp_id); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_issue_ready got=%b exp=0000", req_ready); end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
  endtask
  task automatic test_single();
    do_reset();
    req_a = 32'h000F0000;
    req_b = 32'h00A00000;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", rsp_valid); end
    total++; if (op_a !== 8'h0F || op_b !== 8'hA0) begin bad++; $display("FAIL single_ops got=%h/%h exp=0f/a0", op_a, op_b); end
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_z !== 8'hAF || rsp_id !== 2'd2) begin bad++; $display("FAIL single_rsp got v=%b z=%h id=%0d exp v=1 z=af id=2", rsp_valid, rsp_z, rsp_id); end
    tick();
    total++; if (rsp_valid !== 1'b0 || done_cnt !== 16'd1) begin bad++; $display("FAIL single_done got v=%b cnt=%0d exp v=0 cnt=1", rsp_valid, done_cnt); end
  endtask
  task automatic test_round_robin();
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_z [5] = '{8'h11, 8'h22, 8'h43, 8'h84, 8'h11};
    do_reset();
    req_a = 32'h04030201;
    req_b = 32'h80402010;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (req_ready !== (4'b0001 << exp_id[i])) begin bad++; $display("FAIL rr_grant%0d got=%b exp_id=%0d", i, req_ready, exp_id[i]); end
      tick();
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_issue_ready%0d got=%b exp=0000", i, req_ready); end
      tick();
      total++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id[i] || rsp_z !== exp_z[i] || req_ready !== 4'b0000) begin bad++; $display("FAIL rr_rsp%0d got v=%b id=%0d z=%h rdy=%b exp v=1 id=%0d z=%h rdy=0000", i, rsp_valid, rsp_id, rsp_z, req_ready, exp_id[i], exp_z[i]); end
      tick();
    end
    total++; if (done_cnt !== 16'd5) begin bad++; $display("FAIL rr_done_cnt got=%0d exp=5", done_cnt); end
    req_valid = '0;
  endtask
  task automatic test_backpressure();
    do_reset();
    req_a = 32'h04030201;
    req_b = 32'h80402010;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_z !== 8'h22 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold%0d got v=%b z=%h id=%0d rdy=%b exp v=1 z=22 id=1 rdy=0000", i, rsp_valid, rsp_z, rsp_id, req_ready); end
      tick();
    end
    total++; if (done_cnt !== 16'd0) begin bad++; $display("FAIL bp_no_done got=%0d exp=0", done_cnt); end
    rsp_ready = 1'b1;
    tick();
    total++; if (rsp_valid !== 1'b0 || done_cnt !== 16'd1) begin bad++; $display("FAIL bp_release got v=%b cnt=%0d exp v=0 cnt=1", rsp_valid, done_cnt); end
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_next_grant got=%b exp=0100", req_ready); end
    req_valid = '0;
  endtask
  task automatic test_reset_mid_op();
    do_reset();
    req_a = 32'h04030201;
    req_b = 32'h80402010;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    tick();
    req_valid = 4'hF;
    reset = 1'b1;
    tick();
    total++; if (rsp_valid !== 1'b0 || done_cnt !== 16'd0 || req_ready !== 4'b0000) begin bad++; $display("FAIL mid_reset got v=%b cnt=%0d rdy=%b exp v=0 cnt=0 rdy=0000", rsp_valid, done_cnt, req_ready); end
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_next_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 8'h11) begin bad++; $display("FAIL mid_rsp got v=%b id=%0d z=%h exp v=1 id=0 z=11", rsp_valid, rsp_id, rsp_z); end
    tick();
    total++; if (done_cnt !== 16'd1) begin bad++; $display("FAIL mid_done got=%0d exp=1", done_cnt); end
  endtask
  task automatic test_wrap();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tick();
      tick();
      total++; if (done_cnt2 !== exp_cnt[i]) begin bad++; $display("FAIL wrap%0d got=%0d exp=%0d", i, done_cnt2, exp_cnt[i]); end
    end
    total++; if (done_cnt !== 16'd5) begin bad++; $display("FAIL wrap_wide got=%0d exp=5", done_cnt); end
    req_valid = '0;
  endtask
  initial begin
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
